// File: rtl/shifter_right_serial.sv
// Serial arithmetic right shifter: one bit position per clock, shift amount
// saturated at N, negative shift amounts rejected with an error flag.
module shifter_right_serial #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_out,
    output logic         o_ERR,
    output logic         o_busy,
    output logic         o_done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  N_LIM   = N'(N);
    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  work_q, work_d;
    logic [N-1:0]  out_q, out_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [N-1:0]  work_shr;
    logic [CW-1:0] count_load;

    // One-position arithmetic shift: each bit takes its upper neighbour,
    // the sign bit replicates itself.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_shr
            assign work_shr[gi] = work_q[gi + 1];
        end
    endgenerate
    assign work_shr[N-1] = work_q[N-1];

    // Shifting N or more positions all give the same result, so the
    // counter only has to reach N.
    always_comb begin
        count_load = i_b[CW-1:0];
        if (i_b >= N_LIM) begin
            count_load = N_CNT;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_b[N-1]) begin
                        err_d   = 1'b1;
                        out_d   = '0;
                        state_d = DONE;
                    end else begin
                        work_d  = i_a;
                        count_d = count_load;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    work_d  = work_shr;
                    count_d = count_q - CNT_ONE;
                end else begin
                    out_d   = work_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign o_out  = out_q;
    assign o_ERR  = err_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_shifter_right_serial.sv
// Directed self-checking bench for shifter_right_serial (N = 8).
module tb_shifter_right_serial;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic [7:0] o_out;
    logic       o_ERR;
    logic       o_busy;
    logic       o_done;

    int checks;
    int errors;

    shifter_right_serial #(.N(8)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_out  (o_out),
        .o_ERR  (o_ERR),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Present a request for exactly one edge; returns 1 ns after that edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count edges (the start edge is edge 1) until o_done is seen; bounded.
    task automatic wait_done(input logic [7:0] prev_out, output int lat, output bit stable);
        lat    = 1;
        stable = 1'b1;
        while (o_done !== 1'b1 && lat < 40) begin
            if (o_out !== prev_out) stable = 1'b0;
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_out !== 8'h00 || o_ERR !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%h err=%b busy=%b done=%b, required 00/0/0/0",
                     o_out, o_ERR, o_busy, o_done);
        end
        $display("reset: out=%h err=%b busy=%b done=%b", o_out, o_ERR, o_busy, o_done);
    endtask

    task automatic test_basic();
        int lat;
        bit stable;
        issue(8'h90, 8'd3);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b, required 1", o_busy);
        end
        wait_done(8'h00, lat, stable);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: %0d edges, required 5", lat);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL basic_out_during_shift: out changed before DONE, required held at 00");
        end
        checks++;
        if (o_out !== 8'hF2 || o_ERR !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: out=%h err=%b, required F2/0", o_out, o_ERR);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b busy=%b, required 0/0", o_done, o_busy);
        end
        $display("basic: a=90 b=3 out=%h lat=%0d", o_out, lat);
    endtask

    task automatic test_patterns();
        int lat;
        bit stable;
        issue(8'h40, 8'd2);
        wait_done(8'hF2, lat, stable);
        checks++;
        if (o_out !== 8'h10 || lat !== 4 || stable !== 1'b1) begin
            errors++;
            $display("FAIL pat_40_2: out=%h lat=%0d stable=%b, required 10/4/1", o_out, lat, stable);
        end
        $display("pattern: a=40 b=2 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
        issue(8'h55, 8'd0);
        wait_done(8'h10, lat, stable);
        checks++;
        if (o_out !== 8'h55 || lat !== 2) begin
            errors++;
            $display("FAIL pat_55_0: out=%h lat=%0d, required 55/2", o_out, lat);
        end
        $display("pattern: a=55 b=0 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_error();
        int lat;
        bit stable;
        issue(8'h12, 8'h80);
        wait_done(8'h55, lat, stable);
        checks++;
        if (o_ERR !== 1'b1 || o_out !== 8'h00 || lat !== 1) begin
            errors++;
            $display("FAIL error_req: err=%b out=%h lat=%0d, required 1/00/1", o_ERR, o_out, lat);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_ERR !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: busy=%b err=%b, required 0/1", o_busy, o_ERR);
        end
        $display("error: a=12 b=80 err=%b out=%h lat=%0d", o_ERR, o_out, lat);
    endtask

    task automatic test_saturate();
        int lat;
        bit stable;
        issue(8'h90, 8'd20);
        checks++;
        if (o_ERR !== 1'b0) begin
            errors++;
            $display("FAIL sat_err_clear: err=%b, required 0", o_ERR);
        end
        wait_done(8'h00, lat, stable);
        checks++;
        if (o_out !== 8'hFF || lat !== 10) begin
            errors++;
            $display("FAIL sat_90: out=%h lat=%0d, required FF/10", o_out, lat);
        end
        $display("saturate: a=90 b=20 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
        issue(8'h7F, 8'd20);
        wait_done(8'hFF, lat, stable);
        checks++;
        if (o_out !== 8'h00 || lat !== 10) begin
            errors++;
            $display("FAIL sat_7F: out=%h lat=%0d, required 00/10", o_out, lat);
        end
        $display("saturate: a=7F b=20 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int lat;
        bit stable;
        int extra_done;
        issue(8'h90, 8'd3);
        // Competing request while shifting, with different operands.
        i_a     = 8'h7F;
        i_b     = 8'd1;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_a     = 8'h33;
        i_b     = 8'd5;
        wait_done(8'h00, lat, stable);
        lat = lat + 1;
        checks++;
        if (o_out !== 8'hF2 || lat !== 5) begin
            errors++;
            $display("FAIL ignore_shift: out=%h lat=%0d, required F2/5", o_out, lat);
        end
        // Competing request while in DONE.
        i_a     = 8'h01;
        i_b     = 8'd0;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_done === 1'b1 || o_busy === 1'b1) extra_done++;
            @(posedge i_clk);
            #1;
        end
        checks++;
        if (extra_done !== 0 || o_out !== 8'hF2) begin
            errors++;
            $display("FAIL ignore_done: busy/done cycles=%0d out=%h, required 0/F2", extra_done, o_out);
        end
        $display("ignore: out=%h lat=%0d extra=%0d", o_out, lat, extra_done);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit stable;
        int seen_done;
        issue(8'hA5, 8'd6);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_out !== 8'h00 || o_done !== 1'b0 || o_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b out=%h done=%b err=%b, required 0/00/0/0",
                     o_busy, o_out, o_done, o_ERR);
        end
        // Immediately after reset release a new request must be taken.
        issue(8'h80, 8'd1);
        seen_done = 0;
        wait_done(8'h00, lat, stable);
        checks++;
        if (o_out !== 8'hC0 || lat !== 3 || stable !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover: out=%h lat=%0d stable=%b, required C0/3/1", o_out, lat, stable);
        end
        $display("reset_mid: recover out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit stable;
        issue(8'h81, 8'd7);
        wait_done(8'hC0, lat, stable);
        checks++;
        if (o_out !== 8'hFF || lat !== 9) begin
            errors++;
            $display("FAIL b2b_81_7: out=%h lat=%0d, required FF/9", o_out, lat);
        end
        $display("b2b: a=81 b=7 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
        issue(8'h7F, 8'd6);
        wait_done(8'hFF, lat, stable);
        checks++;
        if (o_out !== 8'h01 || lat !== 8 || stable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_7F_6: out=%h lat=%0d stable=%b, required 01/8/1", o_out, lat, stable);
        end
        $display("b2b: a=7F b=6 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
        issue(8'hC3, 8'd8);
        wait_done(8'h01, lat, stable);
        checks++;
        if (o_out !== 8'hFF || lat !== 10) begin
            errors++;
            $display("FAIL b2b_C3_8: out=%h lat=%0d, required FF/10", o_out, lat);
        end
        $display("b2b: a=C3 b=8 out=%h lat=%0d", o_out, lat);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_a     = 8'h00;
        i_b     = 8'h00;
        test_reset();
        test_basic();
        test_patterns();
        test_error();
        test_saturate();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_right_serial.md
SHIFTER_RIGHT_SERIAL -- requirements
Module: shifter_right_serial

Interface
REQ-001 SHALL have parameter N, default 8, operand and result width in bits.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port i_a  input  N  signed operand (two's complement) to shift right.
REQ-006 SHALL have port i_b  input  N  signed shift amount; MSB set = negative = illegal.
REQ-007 SHALL have port o_out  output  N  registered result.
REQ-008 SHALL have port o_ERR  output  1  registered error flag: negative shift amount.
REQ-009 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 SHALL, in IDLE with i_start=1 and i_b[N-1]=0: load the working register with i_a, load count = min(i_b, N), clear o_ERR, and go to SHIFT.
REQ-013 SHALL, in IDLE with i_start=1 and i_b[N-1]=1: set o_ERR=1 and o_out=0, and go directly to DONE without shifting.
REQ-014 SHALL, in SHIFT with count>0, shift the working register right by one bit per cycle, fill the MSB with the current MSB (arithmetic shift), and decrement count.
REQ-015 SHALL, in SHIFT with count=0, copy the working register to o_out and go to DONE.
REQ-016 SHALL hold o_done=1 only while in DONE, exactly one cycle, then return to IDLE.
REQ-017 SHALL give a legal-request latency of count+2 rising edges, from the edge sampling i_start to the first cycle o_done is high.
REQ-018 SHALL give an error-request latency of 1 edge.
REQ-019 SHALL saturate the shift count at N; for any i_b >= N, the result is all copies of i_a[N-1].
REQ-020 SHALL ignore i_start while o_busy=1, including in DONE; no queuing.
REQ-021 SHALL sample i_a and i_b only on the accepting edge; later input changes have no effect on the running operation.
REQ-022 SHALL hold o_out and o_ERR from completion until the next accepted i_start.
REQ-023 SHALL leave o_out unchanged during SHIFT; the result appears only at the transition into DONE.
REQ-024 SHALL use a count register of width ceil(log2(N+1)) bits, with no wrap-around below zero.

Reset
REQ-025 SHALL, on i_rst=1 at a rising edge, force state=IDLE, o_out=0, o_ERR=0, o_done=0, and clear the working register and count.
REQ-026 SHALL give i_rst priority over i_start and over any in-progress operation; a reset mid-SHIFT aborts the operation with no o_done pulse.
REQ-027 SHALL, in the first cycle after i_rst deasserts, accept i_start.

Verification
REQ-028 Bench SHALL check i_a=0x90, i_b=3, start -> o_out=0xF2, o_ERR=0, o_done high 5 edges after the start edge, one cycle wide.
REQ-029 Bench SHALL check i_a=0x40, i_b=2 -> o_out=0x10; and i_a=0x55, i_b=0 -> o_out=0x55 with o_done 2 edges after start.
REQ-030 Bench SHALL check i_a=0x12, i_b=0x80 -> o_ERR=1, o_out=0x00, o_done 1 edge after start, no SHIFT cycles.
REQ-031 Bench SHALL check i_b=20 (saturates to 8): i_a=0x90 -> 0xFF; i_a=0x7F -> 0x00; o_done 10 edges after start.
REQ-032 Bench SHALL check that a second i_start pulsed during SHIFT and during DONE, with different i_a and i_b, is ignored; the result matches the first request and o_busy drops after DONE.
REQ-033 Bench SHALL check i_rst asserted 2 cycles into a 6-bit shift -> next cycle o_busy=0, o_out=0, no o_done; a new request then completes correctly.
